// File: rtl/pma_check_pkg.sv
// pma_check_pkg
//   Types and helpers shared by the PMA/PMP check arbiter and its round-robin picker:
//   - access_type_e : access kind presented to the checker
//   - arb_state_e   : arbiter FSM encoding
//   - PMA_ADDR_W    : default physical address width
//   - access_fault(): permission verdict for one access
package pma_check_pkg;

    localparam int PMA_ADDR_W = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RSVD  = 2'd3
    } access_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // The reserved type faults no matter what the checker reports.
    function automatic logic access_fault(input logic [1:0] acc,
                                          input logic r, input logic w, input logic x);
        logic f;
        case (acc)
            2'd0:    f = ~x;
            2'd1:    f = ~r;
            2'd2:    f = ~w;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pma_rr_picker.sv
// pma_rr_picker
//   Combinational round-robin selector: picks the first set bit of valid_i at or
//   after ptr_i, wrapping modulo N.
//   Ports:
//     valid_i [N]       request vector
//     ptr_i   [IW]      search start index (must be < N)
//     grant_o [N]       one-hot grant (zero when nothing valid)
//     idx_o   [IW]      index of the granted bit
//     any_o             at least one request valid
module pma_rr_picker #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;
    int   j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found && valid_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
                found      = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/pma_check_arbiter.sv
// pma_check_arbiter
//   Shares one combinational PMA/PMP checker among NUM_REQ requesters. A round-robin
//   winner's address/type/privilege is registered onto chk_*, the checker verdict is
//   captured one cycle later, and a registered fault/cacheable response is returned
//   to the winner over rsp_valid/rsp_ready.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for any req_valid; grant issued combinationally
//   CHECK | chk_* driven from latched request; verdict sampled at edge
//   RESP  | rsp_valid[owner] held until rsp_ready[owner]
//
//   Ports:
//     clock, reset (synchronous, active-low)
//     req_valid/req_ready [NUM_REQ], req_addr [NUM_REQ*ADDR_W], req_type/req_priv [NUM_REQ*2]
//     rsp_valid/rsp_ready [NUM_REQ], rsp_fault, rsp_cacheable
//     chk_addr/chk_type/chk_priv to checker; chk_r/chk_w/chk_x/chk_cacheable from checker
//     fault_count [16], fault_addr [ADDR_W] -- only with PMA_CHECK_ARB_FAULT_LOG_EN defined
module pma_check_arbiter
    import pma_check_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = PMA_ADDR_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*2-1:0]      req_type,
    input  logic [NUM_REQ*2-1:0]      req_priv,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      rsp_fault,
    output logic                      rsp_cacheable,
    output logic [ADDR_W-1:0]         chk_addr,
    output logic [1:0]                chk_type,
    output logic [1:0]                chk_priv,
    input  logic                      chk_r,
    input  logic                      chk_w,
    input  logic                      chk_x,
    input  logic                      chk_cacheable
`ifdef PMA_CHECK_ARB_FAULT_LOG_EN
    ,
    output logic [15:0]               fault_count,
    output logic [ADDR_W-1:0]         fault_addr
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        acc_type_q, acc_type_d;
    logic [1:0]        priv_q, priv_d;
    logic              fault_q, fault_d;
    logic              cache_q, cache_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               rsp_hs;

    pma_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign rsp_hs = (state_q == RESP) && rsp_ready[owner_q];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        acc_type_d = acc_type_q;
        priv_d     = priv_q;
        fault_d    = fault_q;
        cache_d    = cache_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready  = pick_oh;
                    owner_d    = pick_idx;
                    addr_d     = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    acc_type_d = req_type[int'(pick_idx)*2 +: 2];
                    priv_d     = req_priv[int'(pick_idx)*2 +: 2];
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                fault_d = access_fault(acc_type_q, chk_r, chk_w, chk_x);
                cache_d = chk_cacheable & ~fault_d;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    fault_d  = 1'b0;
                    cache_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            addr_q     <= '0;
            acc_type_q <= '0;
            priv_q     <= '0;
            fault_q    <= 1'b0;
            cache_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            acc_type_q <= acc_type_d;
            priv_q     <= priv_d;
            fault_q    <= fault_d;
            cache_q    <= cache_d;
        end
    end

    // Checker sees zeros while idle so stale addresses never leak onto its inputs.
    assign chk_addr      = (state_q == IDLE) ? '0 : addr_q;
    assign chk_type      = (state_q == IDLE) ? '0 : acc_type_q;
    assign chk_priv      = (state_q == IDLE) ? '0 : priv_q;
    assign rsp_valid     = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_fault     = fault_q;
    assign rsp_cacheable = cache_q;

`ifdef PMA_CHECK_ARB_FAULT_LOG_EN
    logic [15:0]       fault_count_q;
    logic [ADDR_W-1:0] fault_addr_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fault_count_q <= '0;
            fault_addr_q  <= '0;
        end else if (rsp_hs && fault_q) begin
            if (fault_count_q == 16'd0) fault_addr_q <= addr_q;
            if (fault_count_q != 16'hFFFF) fault_count_q <= fault_count_q + 16'd1;
        end
    end

    assign fault_count = fault_count_q;
    assign fault_addr  = fault_addr_q;
`endif

endmodule

// File: tb/tb_pma_check_arbiter.sv
module tb_pma_check_arbiter;
    import pma_check_pkg::*;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h8000_0040;
    localparam logic [31:0] A2 = 32'h2000_0200;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*2-1:0]   req_type, req_priv;
    logic              rsp_fault, rsp_cacheable;
    logic [AW-1:0]     chk_addr;
    logic [1:0]        chk_type, chk_priv;
    logic              chk_r, chk_w, chk_x, chk_cacheable;
`ifdef PMA_CHECK_ARB_FAULT_LOG_EN
    logic [15:0]       fault_count;
    logic [AW-1:0]     fault_addr;
`endif

    pma_check_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_type      (req_type),
        .req_priv      (req_priv),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_fault     (rsp_fault),
        .rsp_cacheable (rsp_cacheable),
        .chk_addr      (chk_addr),
        .chk_type      (chk_type),
        .chk_priv      (chk_priv),
        .chk_r         (chk_r),
        .chk_w         (chk_w),
        .chk_x         (chk_x),
        .chk_cacheable (chk_cacheable)
`ifdef PMA_CHECK_ARB_FAULT_LOG_EN
        ,
        .fault_count   (fault_count),
        .fault_addr    (fault_addr)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] valid;
        logic [5:0] types;
        logic [5:0] privs;
        logic       r, w, x, c;
        int         g;
        logic       ef, ec;
    } vec_t;

    vec_t vecs[8];
    int n_vec = 0;
    int n_fail = 0;
    logic [15:0] m_count;
    logic [31:0] m_faddr;
    logic [NR*AW-1:0] addrs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic log_fault(input logic f, input logic [31:0] a);
        if (f) begin
            if (m_count == 16'd0) m_faddr = a;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
    endtask

    task automatic check_log();
`ifdef PMA_CHECK_ARB_FAULT_LOG_EN
        check("fault_count", fault_count, m_count);
        check("fault_addr", fault_addr, m_faddr);
`endif
    endtask

    initial begin
        int g;
        logic [2:0] oh;
        int grp, ph;

        reset = 1'b0;
        req_valid = '0; req_addr = '0; req_type = '0; req_priv = '0; rsp_ready = '0;
        chk_r = 0; chk_w = 0; chk_x = 0; chk_cacheable = 0;
        m_count = '0; m_faddr = '0;
        addrs = {A2, A1, A0};

        //          valid   types      privs      r  w  x  c  g  ef ec
        vecs[0] = '{3'b010, 6'b010101, 6'b110100, 1, 0, 0, 1, 1, 0, 1};
        vecs[1] = '{3'b001, 6'b010110, 6'b110100, 1, 0, 1, 1, 0, 1, 0};
        vecs[2] = '{3'b100, 6'b110101, 6'b110100, 1, 1, 1, 1, 2, 1, 0};
        vecs[3] = '{3'b111, 6'b010101, 6'b101110, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{3'b111, 6'b100100, 6'b110100, 0, 1, 1, 1, 1, 1, 0};
        vecs[5] = '{3'b101, 6'b100100, 6'b110100, 0, 1, 1, 1, 2, 0, 1};
        vecs[6] = '{3'b110, 6'b100001, 6'b110100, 1, 1, 0, 1, 1, 1, 0};
        vecs[7] = '{3'b011, 6'b010100, 6'b110100, 0, 0, 1, 1, 0, 0, 1};

        step; step; #1;
        check("rst req_ready", req_ready, 3'b000);
        check("rst rsp_valid", rsp_valid, 3'b000);
        check("rst rsp_fault", rsp_fault, 1'b0);
        check("rst rsp_cacheable", rsp_cacheable, 1'b0);
        check("rst chk_addr", chk_addr, 32'h0);
        check("rst chk_type", chk_type, 2'b00);
        check("rst chk_priv", chk_priv, 2'b00);
        check_log();
        reset = 1'b1;
        step;

        for (int i = 0; i < 8; i++) begin
            g  = vecs[i].g;
            oh = 3'(1 << g);
            req_valid = vecs[i].valid; req_addr = addrs;
            req_type = vecs[i].types;  req_priv = vecs[i].privs;
            chk_r = vecs[i].r; chk_w = vecs[i].w; chk_x = vecs[i].x; chk_cacheable = vecs[i].c;
            rsp_ready = '0;
            #1;
            check("grant req_ready", req_ready, oh);
            check("idle chk_addr", chk_addr, 32'h0);
            check("idle rsp_valid", rsp_valid, 3'b000);
            step;
            req_valid = '0;
            #1;
            check("check req_ready", req_ready, 3'b000);
            check("check chk_addr", chk_addr, addrs[g*AW +: AW]);
            check("check chk_type", chk_type, vecs[i].types[g*2 +: 2]);
            check("check chk_priv", chk_priv, vecs[i].privs[g*2 +: 2]);
            check("check rsp_valid", rsp_valid, 3'b000);
            step; #1;
            check("resp rsp_valid", rsp_valid, oh);
            check("resp rsp_fault", rsp_fault, vecs[i].ef);
            check("resp rsp_cacheable", rsp_cacheable, vecs[i].ec);
            rsp_ready = oh;
            step;
            rsp_ready = '0;
            log_fault(vecs[i].ef, addrs[g*AW +: AW]);
            #1;
            check("post rsp_valid", rsp_valid, 3'b000);
            check("post chk_addr", chk_addr, 32'h0);
            check_log();
        end

        // Stalled response: rr_ptr is 1, only requester 1 valid; its load faults.
        req_addr = addrs; req_type = 6'b010101; req_priv = 6'b110100;
        chk_r = 0; chk_w = 1; chk_x = 1; chk_cacheable = 1;
        req_valid = 3'b010; rsp_ready = '0;
        #1;
        check("stall grant", req_ready, 3'b010);
        step;
        req_valid = 3'b101;
        #1;
        check("stall check req_ready", req_ready, 3'b000);
        step;
        rsp_ready = 3'b101;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("stall rsp_valid", rsp_valid, 3'b010);
            check("stall rsp_fault", rsp_fault, 1'b1);
            check("stall rsp_cacheable", rsp_cacheable, 1'b0);
            check("stall req_ready", req_ready, 3'b000);
            check("stall chk_addr", chk_addr, A1);
            chk_r = ~chk_r;
            step; #1;
        end
        rsp_ready = 3'b010;
        step;
        rsp_ready = '0;
        log_fault(1'b1, A1);
        #1;
        check("stall release rsp_valid", rsp_valid, 3'b000);
        check("rr after owner 1", req_ready, 3'b100);
        check_log();

        // Reset while requester 2's access sits in CHECK.
        step;
        reset = 1'b0; req_valid = '0;
        #1;
        check("pre-reset chk_addr", chk_addr, A2);
        step; #1;
        check("mid-reset rsp_valid", rsp_valid, 3'b000);
        check("mid-reset req_ready", req_ready, 3'b000);
        check("mid-reset chk_addr", chk_addr, 32'h0);
        check("mid-reset chk_type", chk_type, 2'b00);
        check("mid-reset rsp_fault", rsp_fault, 1'b0);
        m_count = '0; m_faddr = '0;
        check_log();

        // Continuous traffic from all requesters: grants 0,1,2,0 one per 3 cycles.
        reset = 1'b1;
        req_valid = 3'b111; rsp_ready = 3'b111; req_type = 6'b010101;
        chk_r = 1; chk_w = 0; chk_x = 0; chk_cacheable = 1;
        #1;
        for (int c = 0; c < 12; c++) begin
            grp = (c / 3) % 3;
            ph  = c % 3;
            check("stream req_ready", req_ready, (ph == 0) ? 3'(1 << grp) : 3'b000);
            check("stream rsp_valid", rsp_valid, (ph == 2) ? 3'(1 << grp) : 3'b000);
            if (ph == 1) check("stream chk_addr", chk_addr, addrs[grp*AW +: AW]);
            if (ph == 2) check("stream rsp_cacheable", rsp_cacheable, 1'b1);
            step; #1;
        end
        check_log();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pma_check_arbiter.md
# pma_check_arbiter

Shares one combinational PMA/PMP access checker among several requesters: instruction fetch, load/store unit and debug module. It arbitrates requests round-robin, registers the selected address/type/privilege into the checker, captures the checker's verdict one cycle later, and returns a registered fault/cacheable response to the winning requester over a valid/ready handshake. It sits between the core's address-generating units and the PMA/PMP check block.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; 2..8
- ADDR_W, 32, physical address width

Ports:
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_type  in  NUM_REQ*2  access type: 0 fetch, 1 load, 2 store, 3 reserved
- req_priv  in  NUM_REQ*2  privilege mode of the access
- rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_fault  out  1  access denied
- rsp_cacheable  out  1  region cacheable (0 when rsp_fault)
- chk_addr  out  ADDR_W  address to checker
- chk_type  out  2  type to checker
- chk_priv  out  2  privilege to checker
- chk_r / chk_w / chk_x  in  1 each  checker permissions for chk_addr
- chk_cacheable  in  1  checker cacheable attribute
- fault_count  out  16  faults seen (only with PMA_CHECK_ARB_FAULT_LOG_EN)
- fault_addr  out  ADDR_W  first faulting address (only with PMA_CHECK_ARB_FAULT_LOG_EN)

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE: if any req_valid, grant the first valid requester at or after rr_ptr (wrapping modulo NUM_REQ); req_ready[grant] asserted combinationally that cycle; addr/type/priv and owner index latched; go to CHECK. No valid: stay.
- CHECK: chk_* driven from latched regs; verdict sampled at end of cycle; go to RESP.
- Fault rule: fetch requires chk_x, load requires chk_r, store requires chk_w; type 3 always faults; checker inputs ignored for type 3.
- RESP: rsp_valid[owner]=1, rsp_fault/rsp_cacheable stable. On rsp_ready[owner]: rr_ptr = owner+1 (wrap), go to IDLE. rsp_ready from non-owners ignored.
- chk_* drive zero in IDLE; hold latched values in CHECK and RESP.
- req_ready is 0 in CHECK and RESP; new requests wait.

## Timing
- Reset (reset==0 at a clock edge): state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_fault 0, rsp_cacheable 0, chk_* 0, fault_count 0, fault_addr 0.
- Accept at edge T → rsp_valid high from T+2; minimum 3 cycles per transaction; no back-to-back overlap.
- Reset mid-transaction: transaction dropped, no response, state IDLE next cycle.
- Requester dropping req_valid after grant has no effect; transaction completes.
- Response held indefinitely while rsp_ready[owner] is 0.

## Configuration
- PMA_CHECK_ARB_FAULT_LOG_EN defined: on every RESP handshake with rsp_fault=1, fault_count increments, saturating at 16'hFFFF; fault_addr captures the address only when fault_count was 0.
- Undefined: fault_count and fault_addr ports and logic absent; no other behaviour change.

## Structure
- Shared package pma_check_pkg: access-type enum (FETCH, LOAD, STORE, RSVD), FSM state enum, ADDR_W default constant.
- One sub-module: pma_rr_picker, a combinational round-robin first-set-from-pointer selector (valid vector, pointer → one-hot grant, index).

## Test plan
- Single load from req 1, addr 0x8000_0040, chk_r=1, chk_cacheable=1 → rsp_valid[1] at T+2, fault=0, cacheable=1.
- Store from req 0, chk_w=0 → rsp_fault=1, rsp_cacheable=0; with macro, fault_count=1, fault_addr=store address.
- All three requesters valid continuously with rsp_ready=1 → grants 0,1,2,0 repeating, one per 3 cycles.
- Type 3 from req 2 with chk_r/w/x all 1 → rsp_fault=1.
- rsp_ready held 0 for 10 cycles → response stable, req_ready 0 throughout, no new grant.
- reset=0 asserted in CHECK → next cycle all outputs 0, no rsp_valid; next request granted to requester 0 first.
